// File: rtl/level_event_capture.sv
// level_event_capture
//   Destination-domain consumer of an already-synchronized level. The level
//   is debounced, each qualified edge produces a one-cycle rise/fall pulse,
//   and every edge is logged as {edge, timestamp} into a small
//   first-word-fall-through FIFO. A downstream controller drains the FIFO
//   over a valid/ready handshake. A sticky flag records dropped events.
//
// Ports
//   clk_dest        in   destination-domain clock
//   rst_dest        in   synchronous, active-high reset
//   sig_level_dest  in   synchronized input level
//   level_filt      out  debounced level
//   rise_pulse      out  one-cycle pulse on filtered 0->1
//   fall_pulse      out  one-cycle pulse on filtered 1->0
//   evt_valid       out  FIFO non-empty
//   evt_ready       in   consumer accepts the head entry
//   evt_edge        out  head entry edge type (1 = rise, 0 = fall)
//   evt_ts          out  head entry timestamp
//   evt_count       out  FIFO occupancy
//   evt_overflow    out  sticky: an event was dropped on a full FIFO
//   clr_overflow    in   clears evt_overflow (a same-cycle drop wins)
module level_event_capture #(
    parameter int FILTER_CYCLES = 4,
    parameter int TS_WIDTH      = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk_dest,
    input  logic                          rst_dest,
    input  logic                          sig_level_dest,
    output logic                          level_filt,
    output logic                          rise_pulse,
    output logic                          fall_pulse,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic                          evt_edge,
    output logic [TS_WIDTH-1:0]           evt_ts,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          evt_overflow,
    input  logic                          clr_overflow
);

    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = TS_WIDTH + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    logic                level_q, level_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                rise_q, fall_q;
    logic [TS_WIDTH-1:0] ts_q;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_q, wr_d;
    logic [AW-1:0]       rd_q, rd_d;
    logic [AW:0]         count_q, count_d;
    logic [EW-1:0]       head_q, head_d;
    logic                ovf_q, ovf_d;

    logic                update;
    logic [EW-1:0]       new_entry;
    logic                full;
    logic                pop;
    logic                drop;
    logic                push_ok;
    logic [AW:0]         remaining;

    // Debounce: the input must disagree with the filtered level for
    // FILTER_CYCLES consecutive edges; any agreeing cycle restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        update  = 1'b0;
        if (sig_level_dest != level_q) begin
            if (cnt_q == CNT_LAST) begin
                update  = 1'b1;
                level_d = sig_level_dest;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Event FIFO control. A full FIFO still accepts a push when the head is
    // popped in the same cycle, because the freed slot is the one written.
    always_comb begin
        new_entry = {sig_level_dest, ts_q};
        full      = (count_q == DEPTH_C);
        pop       = (count_q != '0) && evt_ready;
        drop      = update && full && !pop;
        push_ok   = update && !drop;
        count_d   = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
        rd_d      = rd_q + AW'(pop);
        wr_d      = wr_q + AW'(push_ok);
        remaining = count_q - (AW + 1)'(pop);
        ovf_d     = drop | (ovf_q & ~clr_overflow);

        // Registered head: next head is either the surviving oldest entry or,
        // when nothing older survives, the entry being pushed. When the FIFO
        // goes empty the last head is kept.
        head_d = head_q;
        if (count_d != '0) begin
            if (remaining == '0) begin
                head_d = new_entry;
            end else begin
                head_d = mem_q[rd_d];
            end
        end
    end

    always_ff @(posedge clk_dest) begin
        if (rst_dest) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            ts_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= update & sig_level_dest;
            fall_q  <= update & ~sig_level_dest;
            ts_q    <= ts_q + 1'b1;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            head_q  <= head_d;
            ovf_q   <= ovf_d;
            if (push_ok) begin
                mem_q[wr_q] <= new_entry;
            end
        end
    end

    assign level_filt   = level_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign evt_valid    = (count_q != '0);
    assign evt_edge     = head_q[EW-1];
    assign evt_ts       = head_q[TS_WIDTH-1:0];
    assign evt_count    = count_q;
    assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_level_event_capture.sv
module tb_level_event_capture;

    localparam int FILT  = 4;
    localparam int TSW   = 4;
    localparam int DEPTH = 4;

    logic           clk;
    logic           rst;
    logic           sig;
    logic           ready;
    logic           clr;
    logic           level_filt;
    logic           rise_pulse;
    logic           fall_pulse;
    logic           evt_valid;
    logic           evt_edge;
    logic [TSW-1:0] evt_ts;
    logic [2:0]     evt_count;
    logic           evt_overflow;

    level_event_capture #(
        .FILTER_CYCLES(FILT),
        .TS_WIDTH     (TSW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_dest      (clk),
        .rst_dest      (rst),
        .sig_level_dest(sig),
        .level_filt    (level_filt),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse),
        .evt_valid     (evt_valid),
        .evt_ready     (ready),
        .evt_edge      (evt_edge),
        .evt_ts        (evt_ts),
        .evt_count     (evt_count),
        .evt_overflow  (evt_overflow),
        .clr_overflow  (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit sig;
        int lvl;
        int rise;
        int fall;
        int valid;
        int cnt;
        int e;
        int ts;
    } vec_t;

    typedef struct {
        logic           e;
        logic [TSW-1:0] ts;
    } ev_t;

    vec_t tbl [17];
    ev_t  sb [$];
    int   checks   = 0;
    int   failures = 0;
    int   ecnt     = 0;
    logic exp_lvl  = 1'b0;
    logic exp_ovf  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // One clock edge; track edges since reset release, then settle.
    task automatic step();
        @(posedge clk);
        if (rst) ecnt = 0;
        else     ecnt++;
        #1;
    endtask

    task automatic set_row(input int i, input bit r, input bit s, input int lv, input int ri,
                           input int fa, input int va, input int cn, input int e, input int ts);
        tbl[i] = '{r, s, lv, ri, fa, va, cn, e, ts};
    endtask

    task automatic chk_all(input string tag, input int lv, input int ri, input int fa,
                           input int va, input int cn, input int e, input int ts, input int ov);
        chk({tag, "_lvl"},   32'(level_filt),   32'(lv));
        chk({tag, "_rise"},  32'(rise_pulse),   32'(ri));
        chk({tag, "_fall"},  32'(fall_pulse),   32'(fa));
        chk({tag, "_valid"}, 32'(evt_valid),    32'(va));
        chk({tag, "_count"}, 32'(evt_count),    32'(cn));
        chk({tag, "_edge"},  32'(evt_edge),     32'(e));
        chk({tag, "_ts"},    32'(evt_ts),       32'(ts));
        chk({tag, "_ovf"},   32'(evt_overflow), 32'(ov));
    endtask

    task automatic do_reset();
        rst = 1'b1; sig = 1'b0; ready = 1'b0; clr = 1'b0;
        step();
        rst = 1'b0;
        exp_lvl = 1'b0;
        exp_ovf = 1'b0;
        sb.delete();
    endtask

    // Hold a level for n edges with evt_ready low; a qualified change is
    // expected on the FILT-th edge and is queued (or counted as dropped).
    task automatic apply_level(input logic v, input int n);
        logic upd;
        upd = (v != exp_lvl);
        for (int i = 0; i < n; i++) begin
            sig = v;
            step();
            if (upd && i == FILT - 1) begin
                exp_lvl = v;
                chk("upd_lvl",  32'(level_filt), 32'(v));
                chk("upd_rise", 32'(rise_pulse), 32'(v));
                chk("upd_fall", 32'(fall_pulse), 32'(!v));
                if (sb.size() < DEPTH) sb.push_back('{v, TSW'(ecnt - 1)});
                else                   exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic drain(input string nm, input bit mono);
        int prev;
        prev  = -1;
        ready = 1'b1;
        for (int k = 0; k < 2 * DEPTH && sb.size() > 0; k++) begin
            chk({nm, "_valid"}, 32'(evt_valid), 32'd1);
            chk({nm, "_edge"},  32'(evt_edge),  32'(sb[0].e));
            chk({nm, "_ts"},    32'(evt_ts),    32'(sb[0].ts));
            if (mono) chk({nm, "_ts_incr"}, 32'(int'(evt_ts) > prev), 32'd1);
            prev = int'(evt_ts);
            void'(sb.pop_front());
            step();
        end
        chk({nm, "_left"}, 32'(sb.size()), 32'd0);
        ready = 1'b0;
        chk({nm, "_empty_valid"}, 32'(evt_valid), 32'd0);
        chk({nm, "_empty_count"}, 32'(evt_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TSW-1:0] ts_new;

        // Reset state, rise after reset release with input high, glitch rejection.
        //          rst sig lvl rise fall vld cnt e ts
        set_row(0,  1, 0,  0,  0,   0,   0,  0, 0, 0);
        set_row(1,  1, 1,  0,  0,   0,   0,  0, 0, 0);
        set_row(2,  0, 1,  0,  0,   0,   0,  0, 0, 0);
        set_row(3,  0, 1,  0,  0,   0,   0,  0, 0, 0);
        set_row(4,  0, 1,  0,  0,   0,   0,  0, 0, 0);
        set_row(5,  0, 1,  1,  1,   0,   1,  1, 1, 3);
        set_row(6,  0, 1,  1,  0,   0,   1,  1, 1, 3);
        set_row(7,  1, 0,  0,  0,   0,   0,  0, 0, 0);
        set_row(8,  0, 1,  0,  0,   0,   0,  0, 0, 0);
        set_row(9,  0, 1,  0,  0,   0,   0,  0, 0, 0);
        set_row(10, 0, 1,  0,  0,   0,   0,  0, 0, 0);
        set_row(11, 0, 0,  0,  0,   0,   0,  0, 0, 0);
        set_row(12, 0, 0,  0,  0,   0,   0,  0, 0, 0);
        set_row(13, 0, 1,  0,  0,   0,   0,  0, 0, 0);
        set_row(14, 0, 1,  0,  0,   0,   0,  0, 0, 0);
        set_row(15, 0, 1,  0,  0,   0,   0,  0, 0, 0);
        set_row(16, 0, 0,  0,  0,   0,   0,  0, 0, 0);

        rst = 1'b1; sig = 1'b0; ready = 1'b0; clr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst;
            sig = tbl[i].sig;
            step();
            chk_all($sformatf("row%0d", i), tbl[i].lvl, tbl[i].rise, tbl[i].fall,
                    tbl[i].valid, tbl[i].cnt, tbl[i].e, tbl[i].ts, 0);
        end

        // Overflow: five edges with no consumer; clear coincides with the drop.
        do_reset();
        apply_level(1'b1, 4);
        apply_level(1'b0, 4);
        apply_level(1'b1, 4);
        apply_level(1'b0, 4);
        chk("ovf_pre_count", 32'(evt_count), 32'd4);
        chk("ovf_pre_flag",  32'(evt_overflow), 32'd0);
        clr = 1'b1;
        apply_level(1'b1, 4);
        clr = 1'b0;
        chk("ovf_count", 32'(evt_count), 32'd4);
        chk("ovf_flag_set_wins", 32'(evt_overflow), 32'(exp_ovf));
        step();
        chk("ovf_sticky", 32'(evt_overflow), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("ovf_cleared", 32'(evt_overflow), 32'd0);
        drain("ovf_drain", 1'b1);

        // Full FIFO with push and pop on the same edge.
        do_reset();
        apply_level(1'b1, 4);
        apply_level(1'b0, 4);
        apply_level(1'b1, 4);
        apply_level(1'b0, 4);
        sig = 1'b1;
        for (int i = 0; i < FILT - 1; i++) step();
        ready = 1'b1;
        chk("pp_head_edge", 32'(evt_edge), 32'(sb[0].e));
        chk("pp_head_ts",   32'(evt_ts),   32'(sb[0].ts));
        step();
        ready = 1'b0;
        ts_new = TSW'(ecnt - 1);
        void'(sb.pop_front());
        sb.push_back('{1'b1, ts_new});
        exp_lvl = 1'b1;
        chk("pp_count", 32'(evt_count),    32'd4);
        chk("pp_ovf",   32'(evt_overflow), 32'd0);
        chk("pp_rise",  32'(rise_pulse),   32'd1);
        chk("pp_next_edge", 32'(evt_edge), 32'(sb[0].e));
        chk("pp_next_ts",   32'(evt_ts),   32'(sb[0].ts));
        drain("pp_drain", 1'b0);

        // Timestamp wrap: events at edges 4, 15 and 19 record 3, 14, 2.
        do_reset();
        apply_level(1'b1, 4);
        apply_level(1'b1, 7);
        apply_level(1'b0, 4);
        apply_level(1'b1, 4);
        chk("wrap_count", 32'(evt_count), 32'd3);
        drain("wrap_drain", 1'b0);

        // Reset while draining.
        apply_level(1'b0, 4);
        apply_level(1'b1, 4);
        ready = 1'b1;
        step();
        chk("mid_count_before", 32'(evt_count), 32'd1);
        rst = 1'b1;
        step();
        chk_all("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        ready = 1'b0;
        sb.delete();
        step();
        chk("post_rst_valid", 32'(evt_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
